// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI responder path.
//   SPI_DATA_W     default frame width in bits
//   MSB_FIRST      bit order on the wire
//   spi_tx_state_t transmitter states (IDLE, SHIFT, DRAIN)
package spi_pkg;

  localparam int SPI_DATA_W = 16;
  localparam bit MSB_FIRST  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } spi_tx_state_t;

endpackage

// File: rtl/spi_slave_tx_if.sv
// spi_slave_tx_if: bundles the parallel sample handshake, the SPI pins and
// the status pulses of the SPI responder.
//   slave  modport : view of the responder (spi_slave_tx)
//   master modport : view of the sample source / host model
interface spi_slave_tx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              frame_done;
  logic              frame_abort;
  logic              underrun;
  logic              overrun;

  modport slave (
    input  data_in, data_valid, spi_sck, spi_cs_n,
    output data_ready, spi_miso, spi_miso_oe,
    output frame_done, frame_abort, underrun, overrun
  );

  modport master (
    output data_in, data_valid, spi_sck, spi_cs_n,
    input  data_ready, spi_miso, spi_miso_oe,
    input  frame_done, frame_abort, underrun, overrun
  );

endinterface

// File: rtl/sync_ff.sv
// sync_ff: single-bit multi-flop synchronizer for asynchronous pins.
//   clk  in   destination clock
//   d    in   asynchronous input
//   q    out  synchronized output, STAGES clk later
// No reset: the chain must keep tracking the pin through a reset so that a
// pin already held low does not look like a fresh edge once reset releases.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI Mode-0 responder returning filtered samples to the host.
// SCK and CS_n are oversampled in the clk domain; nothing runs on SCK.
//   clk, rst           system clock, synchronous active-high reset
//   bus.data_in/valid  sample word and its single-cycle strobe
//   bus.data_ready     holding register empty (writes are never refused)
//   bus.spi_sck/cs_n   host clock and chip select (asynchronous)
//   bus.spi_miso/_oe   serial data and its tri-state enable
//   bus.frame_done     full DATA_W-bit frame completed
//   bus.frame_abort    CS_n rose before DATA_W bits
//   bus.underrun       frame started with no fresh word (last word resent)
//   bus.overrun        unread held word overwritten
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  spi_slave_tx_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam int               OUT_BIT  = MSB_FIRST ? DATA_W - 1 : 0;

  logic sck_s, cs_n_s, sck_d, cs_n_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  spi_tx_state_t     state_q, state_nx;
  logic [DATA_W-1:0] shift_q, shift_nx;
  logic [DATA_W-1:0] hold_q, hold_nx;
  logic [DATA_W-1:0] last_q, last_nx;
  logic              hold_full_q, hold_full_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              done_q, done_nx, abort_q, abort_nx;
  logic              under_q, under_nx, over_q, over_nx;
  logic              load;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk (clk),
    .d   (bus.spi_sck),
    .q   (sck_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
    .clk (clk),
    .d   (bus.spi_cs_n),
    .q   (cs_n_s)
  );

  // Edge-detect stage: one extra flop behind each synchronizer
  always_ff @(posedge clk) begin
    sck_d  <= sck_s;
    cs_n_d <= cs_n_s;
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_n_s & cs_n_d;
  assign cs_rise  = cs_n_s & ~cs_n_d;

  // A frame start takes priority over a coincident sck_rise, which is simply
  // not counted because only SHIFT counts edges.
  assign load = (state_q == IDLE) && cs_fall;

  always_comb begin
    state_nx     = state_q;
    shift_nx     = shift_q;
    hold_nx      = hold_q;
    last_nx      = last_q;
    hold_full_nx = hold_full_q;
    cnt_nx       = cnt_q;
    done_nx      = 1'b0;
    abort_nx     = 1'b0;
    under_nx     = 1'b0;
    over_nx      = 1'b0;

    if (load) begin
      if (hold_full_q) begin
        shift_nx     = hold_q;
        last_nx      = hold_q;
        // A strobe in the load cycle refills the slot just vacated
        hold_full_nx = bus.data_valid;
        if (bus.data_valid) hold_nx = bus.data_in;
      end else if (bus.data_valid) begin
        shift_nx = bus.data_in;
        last_nx  = bus.data_in;
      end else begin
        shift_nx = last_q;
        under_nx = 1'b1;
      end
      cnt_nx   = '0;
      state_nx = SHIFT;
    end else if (bus.data_valid) begin
      over_nx      = hold_full_q;
      hold_nx      = bus.data_in;
      hold_full_nx = 1'b1;
    end

    case (state_q)
      SHIFT: begin
        if (cs_rise) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          if (sck_rise) begin
            cnt_nx = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_nx = DRAIN;
          end
          if (sck_fall) begin
            shift_nx = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0}
                                 : {1'b0, shift_q[DATA_W-1:1]};
          end
        end
      end
      DRAIN: begin
        if (cs_rise) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: ;
    endcase
  end

  // State / control register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      hold_full_q <= hold_full_nx;
      shift_q     <= shift_nx;
      last_q      <= last_nx;
      cnt_q       <= cnt_nx;
      done_q      <= done_nx;
      abort_q     <= abort_nx;
      under_q     <= under_nx;
      over_q      <= over_nx;
    end
  end

  // Holding data is qualified by hold_full_q and needs no reset
  always_ff @(posedge clk) begin
    hold_q <= hold_nx;
  end

  assign bus.spi_miso    = (state_q == SHIFT) ? shift_q[OUT_BIT] : 1'b0;
  assign bus.spi_miso_oe = (state_q != IDLE);
  assign bus.data_ready  = ~hold_full_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign bus.underrun    = under_q;
  assign bus.overrun     = over_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: directed scoreboard bench for spi_slave_tx.
// Stimulus pushes expected events (received words and status pulses) into a
// queue; a pulse monitor and an SPI receiver pop and compare them.
module tb_spi_slave_tx;
  import spi_pkg::*;

  localparam int DW = 16;

  typedef enum int {EV_WORD, EV_DONE, EV_ABORT, EV_UNDER, EV_OVER} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_tx_if #(.DATA_W(DW)) bus ();

  spi_slave_tx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  function automatic void push_ev(ev_kind_t k, logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void sb_check(ev_kind_t k, logic [31:0] v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got %s 0x%0h, required no event", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.val == v) n_pass++;
      else $display("FAIL event_%s: got %s 0x%0h, required %s 0x%0h",
                    e.kind.name(), k.name(), v, e.kind.name(), e.val);
    end
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endfunction

  // Status pulse monitor
  always @(negedge clk) begin
    if (bus.underrun)    sb_check(EV_UNDER, 32'h0);
    if (bus.overrun)     sb_check(EV_OVER, 32'h0);
    if (bus.frame_done)  sb_check(EV_DONE, 32'h0);
    if (bus.frame_abort) sb_check(EV_ABORT, 32'h0);
  end

  // SPI host receiver: Mode 0, samples MISO on SCK rise, reports at CS rise
  initial begin : rx_mon
    logic [31:0] rx;
    forever begin
      @(negedge bus.spi_cs_n);
      rx = 32'h0;
      while (bus.spi_cs_n == 1'b0) begin
        @(posedge bus.spi_sck or posedge bus.spi_cs_n);
        if (bus.spi_cs_n == 1'b0) rx = {rx[30:0], bus.spi_miso};
      end
      sb_check(EV_WORD, rx);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    tick(1);
    bus.data_valid = 1'b0;
    tick(2);
  endtask

  // Host frame at clk/8. With bypass, data_valid lands in the cs_fall cycle
  // (two synchronizer flops after the pin change). With rst_mid, reset is
  // pulsed after nbits while CS is still low.
  task automatic frame(input int nbits, input bit bypass, input logic [DW-1:0] bw,
                       input bit rst_mid);
    bus.spi_cs_n = 1'b0;
    if (bypass) begin
      tick(2);
      bus.data_in    = bw;
      bus.data_valid = 1'b1;
      tick(1);
      bus.data_valid = 1'b0;
      tick(5);
    end else begin
      tick(8);
    end
    check("miso_oe_selected", 32'(bus.spi_miso_oe), 32'h1);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_sck = 1'b1;
      tick(4);
      bus.spi_sck = 1'b0;
      tick(4);
    end
    if (rst_mid) begin
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_mid_miso_oe", 32'(bus.spi_miso_oe), 32'h0);
      check("rst_mid_miso", 32'(bus.spi_miso), 32'h0);
      check("rst_mid_data_ready", 32'(bus.data_ready), 32'h1);
      tick(3);
    end
    bus.spi_cs_n = 1'b1;
    tick(8);
    check("miso_oe_released", 32'(bus.spi_miso_oe), 32'h0);
  endtask

  task automatic drained(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    tick(4);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s_pending: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.spi_sck    = 1'b0;
    bus.spi_cs_n   = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    rst            = 1'b1;
    tick(5);
    check("rst_data_ready", 32'(bus.data_ready), 32'h1);
    check("rst_miso", 32'(bus.spi_miso), 32'h0);
    check("rst_miso_oe", 32'(bus.spi_miso_oe), 32'h0);
    check("rst_pulses", {28'h0, bus.frame_done, bus.frame_abort, bus.underrun, bus.overrun},
          32'h0);
    rst = 1'b0;
    tick(2);

    // Basic frame
    write_word(16'hA5C3);
    check("ready_after_write", 32'(bus.data_ready), 32'h0);
    push_ev(EV_WORD, 32'hA5C3);
    push_ev(EV_DONE, 32'h0);
    frame(16, 1'b0, '0, 1'b0);
    check("ready_after_frame", 32'(bus.data_ready), 32'h1);
    drained("basic");

    // Underrun: empty after reset, then resend of last word
    do_reset();
    push_ev(EV_UNDER, 32'h0);
    push_ev(EV_WORD, 32'h0000);
    push_ev(EV_DONE, 32'h0);
    frame(16, 1'b0, '0, 1'b0);
    write_word(16'h1234);
    push_ev(EV_WORD, 32'h1234);
    push_ev(EV_DONE, 32'h0);
    frame(16, 1'b0, '0, 1'b0);
    push_ev(EV_UNDER, 32'h0);
    push_ev(EV_WORD, 32'h1234);
    push_ev(EV_DONE, 32'h0);
    frame(16, 1'b0, '0, 1'b0);
    drained("underrun");

    // Overrun: second strobe replaces the unread word
    write_word(16'h1111);
    push_ev(EV_OVER, 32'h0);
    write_word(16'h2222);
    push_ev(EV_WORD, 32'h2222);
    push_ev(EV_DONE, 32'h0);
    frame(16, 1'b0, '0, 1'b0);
    drained("overrun");

    // Short frame: 7 bits then CS rise
    write_word(16'hFFFF);
    push_ev(EV_WORD, 32'h7F);
    push_ev(EV_ABORT, 32'h0);
    frame(7, 1'b0, '0, 1'b0);
    drained("abort");

    // Long frame: 20 SCK cycles, trailing bits read 0
    write_word(16'h8001);
    push_ev(EV_WORD, 32'h80010);
    push_ev(EV_DONE, 32'h0);
    frame(20, 1'b0, '0, 1'b0);
    drained("drain");

    // Bypass load in the cs_fall cycle, reset after 5 bits: host keeps 10111
    push_ev(EV_WORD, 32'h17);
    frame(5, 1'b1, 16'hBEEF, 1'b1);
    drained("bypass_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
